// File: rtl/sar_controller.sv
// ---------------------------------------------------------------------------
// sar_controller
//
// Successive-approximation register controller. It tracks the input while
// the sample strobe is high. A falling sample edge starts a binary search
// that resolves one bit per clock, MSB first, using the comparator result.
// The finished code is handed to a consumer through a valid/ready pair.
//
// Parameters
//   NBITS       conversion resolution in bits (2..16)
//
// Ports
//   clk_in      single clock, rising edge
//   rst         asynchronous active-high reset
//   sample      sample strobe: high = track, falling edge = start conversion
//   comp        comparator result, 1 = Vin >= Vdac(dac_code)
//   dac_code    registered trial code driven to the capacitive DAC
//   busy        high while sampling or converting
//   data        last completed conversion result
//   data_valid  result available; held until accepted
//   data_ready  consumer accepts data when data_valid && data_ready
//   overrun     sticky: an unaccepted result was overwritten
//   abort       one-cycle pulse: conversion cut short by an early sample
// ---------------------------------------------------------------------------
module sar_controller #(
  parameter int NBITS = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sample,
  input  logic             comp,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic [NBITS-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             abort
);

  localparam int PW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [NBITS-1:0] MIDSCALE = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [PW-1:0]    PTR_MAX  = PW'(NBITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] dac_code_q, dac_code_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    ptr_dec;
  logic [NBITS-1:0] data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;
  logic             load;

  assign ptr_dec = ptr_q - PW'(1);

  // Next-state logic. A sample strobe during conversion restarts from
  // midscale without touching the result registers.
  always_comb begin
    state_d      = state_q;
    dac_code_d   = dac_code_q;
    ptr_d        = ptr_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    abort_d      = 1'b0;
    load         = 1'b0;

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample) begin
          state_d    = ST_SAMPLE;
          dac_code_d = MIDSCALE;
          ptr_d      = PTR_MAX;
        end
      end
      ST_SAMPLE: begin
        dac_code_d = MIDSCALE;
        ptr_d      = PTR_MAX;
        if (!sample) begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (sample) begin
          state_d    = ST_SAMPLE;
          dac_code_d = MIDSCALE;
          ptr_d      = PTR_MAX;
          abort_d    = 1'b1;
        end else begin
          // Keep the trial bit only if the input is at or above the DAC.
          dac_code_d[ptr_q] = comp;
          if (ptr_q != '0) begin
            dac_code_d[ptr_dec] = 1'b1;
            ptr_d               = ptr_dec;
          end else begin
            load    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (sample) begin
          state_d    = ST_SAMPLE;
          dac_code_d = MIDSCALE;
          ptr_d      = PTR_MAX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new result wins over a same-cycle accept; an overwrite only counts
    // as overrun when the old result was not being taken on this edge.
    if (load) begin
      data_d       = dac_code_d;
      data_valid_d = 1'b1;
      if (data_valid_q && !data_ready) begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_SAMPLE) || (state_d == ST_CONVERT);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dac_code_q   <= '0;
      ptr_q        <= PTR_MAX;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dac_code_q   <= dac_code_d;
      ptr_q        <= ptr_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
    end
  end

  assign dac_code   = dac_code_q;
  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_sar_controller.sv
// ---------------------------------------------------------------------------
// tb_sar_controller
//
// Directed bench for sar_controller at NBITS=10. The comparator is driven
// either from an ideal model (vin_code >= dac_code) or held at a constant.
// Expected codes are hand-computed binary-search trial sequences.
// ---------------------------------------------------------------------------
module tb_sar_controller;

  localparam int NBITS = 10;

  logic             clk_in;
  logic             rst;
  logic             sample;
  logic             comp;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic [NBITS-1:0] data;
  logic             data_valid;
  logic             data_ready;
  logic             overrun;
  logic             abort;

  int               vectors;
  int               miscompares;
  logic [NBITS-1:0] vin_code;
  int               comp_mode;  // 0 = model, 1 = held high, 2 = held low

  logic [NBITS-1:0] seq_2a5 [10];

  sar_controller #(.NBITS(NBITS)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sample     (sample),
    .comp       (comp),
    .dac_code   (dac_code),
    .busy       (busy),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .abort      (abort)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one clock and settle; the comparator answer for the next edge
  // is derived from the trial code now on the DAC.
  task automatic cyc();
    @(posedge clk_in);
    #1;
    case (comp_mode)
      1:       comp = 1'b1;
      2:       comp = 1'b0;
      default: comp = (vin_code >= dac_code);
    endcase
  endtask

  task automatic do_reset();
    sample     = 1'b0;
    data_ready = 1'b0;
    @(posedge clk_in);
    #2;
    rst = 1'b1;
    #4;
    rst = 1'b0;
    #1;
  endtask

  // One-cycle sample pulse followed by a full conversion; ends in DONE.
  task automatic convert(input logic [NBITS-1:0] vin, input int mode);
    vin_code  = vin;
    comp_mode = mode;
    sample    = 1'b1;
    cyc();
    sample = 1'b0;
    for (int i = 0; i < 11; i++) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    vectors += 6;
    if (dac_code !== 10'h000) begin miscompares++; $display("[TB] FAIL reset_dac got %h want %h", dac_code, 10'h000); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (data !== 10'h000) begin miscompares++; $display("[TB] FAIL reset_data got %h want %h", data, 10'h000); end
    if (data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", data_valid); end
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
    if (abort !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_abort got %b want 0", abort); end
  endtask

  task automatic test_basic_conversion();
    do_reset();
    vin_code  = 10'h2A5;
    comp_mode = 0;
    sample    = 1'b1;
    cyc();
    vectors += 2;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sample_busy got %b want 1", busy); end
    if (dac_code !== 10'h200) begin miscompares++; $display("[TB] FAIL sample_dac got %h want 200", dac_code); end
    sample = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      vectors += 3;
      if (dac_code !== seq_2a5[i]) begin miscompares++; $display("[TB] FAIL trial_%0d got %h want %h", i, dac_code, seq_2a5[i]); end
      if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL convert_busy_%0d got %b want 1", i, busy); end
      if (data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL early_valid_%0d got %b want 0", i, data_valid); end
      cyc();
    end
    vectors += 3;
    if (data !== 10'h2A5) begin miscompares++; $display("[TB] FAIL basic_data got %h want 2a5", data); end
    if (data_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid got %b want 1", data_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL done_busy got %b want 0", busy); end
    cyc();
    vectors += 3;
    if (dac_code !== 10'h2A5) begin miscompares++; $display("[TB] FAIL idle_dac_hold got %h want 2a5", dac_code); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    if (data_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL valid_held got %b want 1", data_valid); end
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    vectors += 2;
    if (data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL accept_valid got %b want 0", data_valid); end
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL accept_overrun got %b want 0", overrun); end
  endtask

  task automatic test_comp_held();
    do_reset();
    convert(10'h000, 1);
    vectors++;
    if (data !== 10'h3FF) begin miscompares++; $display("[TB] FAIL comp_high_data got %h want 3ff", data); end
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    convert(10'h000, 2);
    vectors += 3;
    if (data !== 10'h000) begin miscompares++; $display("[TB] FAIL comp_low_data got %h want 000", data); end
    if (data_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL comp_low_valid got %b want 1", data_valid); end
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL comp_low_overrun got %b want 0", overrun); end
  endtask

  task automatic test_abort();
    do_reset();
    convert(10'h000, 1);
    vin_code  = 10'h2A5;
    comp_mode = 0;
    sample    = 1'b1;
    cyc();
    sample = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    sample = 1'b1;
    cyc();
    sample = 1'b0;
    vectors += 5;
    if (abort !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_pulse got %b want 1", abort); end
    if (dac_code !== 10'h200) begin miscompares++; $display("[TB] FAIL abort_dac got %h want 200", dac_code); end
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_busy got %b want 1", busy); end
    if (data !== 10'h3FF) begin miscompares++; $display("[TB] FAIL abort_data got %h want 3ff", data); end
    if (data_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_valid got %b want 1", data_valid); end
    cyc();
    vectors++;
    if (abort !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_once got %b want 0", abort); end
    for (int i = 0; i < 10; i++) cyc();
    vectors += 2;
    if (data !== 10'h2A5) begin miscompares++; $display("[TB] FAIL post_abort_data got %h want 2a5", data); end
    if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL post_abort_overrun got %b want 1", overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    convert(10'h2A5, 0);
    convert(10'h155, 0);
    vectors += 3;
    if (data !== 10'h155) begin miscompares++; $display("[TB] FAIL overrun_data got %h want 155", data); end
    if (data_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_valid got %b want 1", data_valid); end
    if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_flag got %b want 1", overrun); end
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    cyc();
    vectors += 2;
    if (data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun_accept got %b want 0", data_valid); end
    if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    convert(10'h2A5, 0);
    vin_code = 10'h155;
    sample   = 1'b1;
    cyc();
    sample = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    data_ready = 1'b1;
    cyc();
    data_ready = 1'b0;
    vectors += 3;
    if (data !== 10'h155) begin miscompares++; $display("[TB] FAIL b2b_data got %h want 155", data); end
    if (data_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid got %b want 1", data_valid); end
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  task automatic test_async_reset();
    do_reset();
    vin_code  = 10'h2A5;
    comp_mode = 0;
    sample    = 1'b1;
    cyc();
    sample = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    #2;
    rst = 1'b1;
    #1;
    vectors += 6;
    if (dac_code !== 10'h000) begin miscompares++; $display("[TB] FAIL async_dac got %h want 000", dac_code); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL async_busy got %b want 0", busy); end
    if (data !== 10'h000) begin miscompares++; $display("[TB] FAIL async_data got %h want 000", data); end
    if (data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_valid got %b want 0", data_valid); end
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL async_overrun got %b want 0", overrun); end
    if (abort !== 1'b0) begin miscompares++; $display("[TB] FAIL async_abort got %b want 0", abort); end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    vectors += 3;
    if (data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_valid got %b want 0", data_valid); end
    if (data !== 10'h000) begin miscompares++; $display("[TB] FAIL post_rst_data got %h want 000", data); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_busy got %b want 0", busy); end
    convert(10'h2A5, 0);
    vectors += 2;
    if (data !== 10'h2A5) begin miscompares++; $display("[TB] FAIL rst_reconv_data got %h want 2a5", data); end
    if (data_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_reconv_valid got %b want 1", data_valid); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    sample      = 1'b0;
    comp        = 1'b0;
    data_ready  = 1'b0;
    vin_code    = '0;
    comp_mode   = 0;
    seq_2a5 = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};
    #2;
    test_reset();
    test_basic_conversion();
    test_comp_held();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 The block SHALL have parameter NBITS, default 10: conversion resolution in bits (legal range 2..16).
REQ-002 The block SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port sample  input  1  sample-phase strobe from the timing management unit; high = track input, falling edge = start conversion.
REQ-005 The block SHALL have port comp  input  1  comparator result; 1 = Vin >= Vdac(dac_code).
REQ-006 The block SHALL have port dac_code  output  NBITS  trial code driven to the capacitive DAC (registered).
REQ-007 The block SHALL have port busy  output  1  high while in SAMPLE or CONVERT.
REQ-008 The block SHALL have port data  output  NBITS  last completed conversion result (registered).
REQ-009 The block SHALL have port data_valid  output  1  result available; held until accepted.
REQ-010 The block SHALL have port data_ready  input  1  consumer accepts data in any cycle where data_valid && data_ready.
REQ-011 The block SHALL have port overrun  output  1  sticky flag: an unaccepted result was overwritten.
REQ-012 The block SHALL have port abort  output  1  one-cycle pulse: conversion aborted by an early sample strobe.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SAMPLE, CONVERT, DONE; busy = (SAMPLE or CONVERT).
REQ-014 IDLE -> SAMPLE SHALL occur on the edge where sample=1; otherwise IDLE holds.
REQ-015 On entry to SAMPLE and throughout it, dac_code SHALL equal 1<<(NBITS-1) (midscale) and the bit pointer SHALL equal NBITS-1.
REQ-016 SAMPLE -> CONVERT SHALL occur on the first edge where sample=0; no comp evaluation happens on that edge.
REQ-017 Each CONVERT edge SHALL resolve bit i = pointer: if comp=0, bit i of dac_code is cleared, else kept; if i>0, bit i-1 is set and the pointer decrements.
REQ-018 Conversion SHALL take exactly NBITS CONVERT cycles; on the edge resolving bit 0, data SHALL load the fully resolved code, data_valid SHALL be set, and state SHALL go to DONE.
REQ-019 DONE SHALL last one cycle, then go to SAMPLE if sample=1, else IDLE; dac_code SHALL hold the final code in DONE and IDLE.
REQ-020 sample=1 on any CONVERT edge SHALL abort: state -> SAMPLE, dac_code -> midscale, pointer -> NBITS-1, abort pulses high for one cycle, data/data_valid unchanged.
REQ-021 data_valid SHALL clear on the edge where data_valid && data_ready, unless a new result loads on the same edge, in which case it stays 1 and overrun is not set.
REQ-022 If a new result loads while data_valid=1 and data_ready=0, data SHALL be overwritten with the new result, data_valid stays 1, and overrun SHALL set and remain set until reset.
REQ-023 comp SHALL be ignored outside CONVERT; data_ready SHALL be ignored while data_valid=0.
REQ-024 With the default 1-high/12-low timing frame, one conversion plus DONE (NBITS+1 = 11 cycles) SHALL complete within the low phase, so no abort occurs in normal operation.

Reset
REQ-025 Asserting rst SHALL immediately (asynchronously) force state=IDLE, dac_code=0, pointer=NBITS-1, busy=0, data=0, data_valid=0, overrun=0, abort=0.
REQ-026 Reset asserted mid-conversion SHALL discard the partial result; data and data_valid stay 0 after release.
REQ-027 After rst deasserts, the first state transition SHALL occur on the first rising clk_in edge with rst low.

Verification
REQ-028 NBITS=10, comp modeled as (Vin_code >= dac_code) with Vin_code=0x2A5, sample high 1 cycle -> dac_code sequence 0x200,0x300,0x280,0x2C0,0x2A0,0x2B0,0x2A8,0x2A4,0x2A6,0x2A5; data=0x2A5 with data_valid=1 exactly 11 cycles after sample falls.
REQ-029 comp held 1 -> data=0x3FF; comp held 0 -> data=0x000; busy high from SAMPLE entry through the 10th CONVERT cycle.
REQ-030 sample raised on the 5th CONVERT cycle -> abort pulses once, dac_code=0x200 next cycle, data_valid unchanged, subsequent full conversion correct.
REQ-031 data_ready held 0 across two complete conversions (0x2A5 then 0x155) -> data=0x155, data_valid=1, overrun=1; data_ready=1 for one cycle -> data_valid=0, overrun stays 1.
REQ-032 Result loading on the same edge as data_valid && data_ready -> data_valid remains 1, overrun remains 0.
REQ-033 rst pulsed asynchronously (between clock edges) during CONVERT -> all outputs zero immediately, no data_valid after release until a new full conversion.
